// File: rtl/nzcv_pkg.sv
// Shared definitions for the NZCV condition-flag producer: flag bit positions,
// result-class codes and the 4-bit flag type.
package nzcv_pkg;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef logic [3:0] nzcv_t;

  typedef enum logic [1:0] {
    CLS_LOGIC = 2'b00,
    CLS_ARITH = 2'b01,
    CLS_MUL   = 2'b10,
    CLS_MSR   = 2'b11
  } res_class_e;

endpackage

// File: rtl/nzcv_compute.sv
// Combinational next-flag function: derives the NZCV value an accepted
// flag-setting result would write, given the current flags.
module nzcv_compute
  import nzcv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  nzcv_t             i_nzcv,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_carry,
  input  logic              i_overflow,
  input  logic [1:0]        i_class,
  output nzcv_t             o_nzcv
);

  logic  w_n;
  logic  w_z;
  nzcv_t w_next;

  assign w_n = i_value[DATA_W-1];
  assign w_z = (i_value == {DATA_W{1'b0}});

  // Select which flags each result class overwrites; the rest hold.
  always_comb begin
    w_next = i_nzcv;
    case (res_class_e'(i_class))
      CLS_LOGIC: begin
        w_next[N_IDX] = w_n;
        w_next[Z_IDX] = w_z;
        w_next[C_IDX] = i_carry;
      end
      CLS_ARITH: begin
        w_next[N_IDX] = w_n;
        w_next[Z_IDX] = w_z;
        w_next[C_IDX] = i_carry;
        w_next[V_IDX] = i_overflow;
      end
      // C is architecturally unpredictable after a multiply; keep it.
      CLS_MUL: begin
        w_next[N_IDX] = w_n;
        w_next[Z_IDX] = w_z;
      end
      CLS_MSR: begin
        w_next = i_value[DATA_W-1 -: 4];
      end
      default: begin
        w_next = i_nzcv;
      end
    endcase
  end

  assign o_nzcv = w_next;

endmodule

// File: rtl/nzcv_flag_writer.sv
// Architectural NZCV register plus in-flight S-bit tracking for the condition
// evaluator. Optional zero-cycle forwarding ports under NZCV_BYPASS_EN.
module nzcv_flag_writer
  import nzcv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_s,
  output logic              issue_ready,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_value,
  input  logic              res_carry,
  input  logic              res_overflow,
  input  logic [1:0]        res_class,
  input  logic              res_s,
  input  logic              res_cond_pass,
  input  logic              flush,
`ifdef NZCV_BYPASS_EN
  output logic [3:0]        nzcv_fwd,
  output logic              nzcv_stable_fwd,
`endif
  output logic [3:0]        nzcv_out,
  output logic              nzcv_stable,
  output logic              underflow_err
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  nzcv_t            r_nzcv;
  logic [CNT_W-1:0] r_pending;
  logic             r_err;

  logic             w_accept;
  logic             w_inc;
  logic             w_dec;
  logic             w_upd;
  logic             w_underflow;
  logic [CNT_W-1:0] w_pending_nxt;
  nzcv_t            w_nzcv_nxt;

  assign res_ready   = !rst && !flush;
  assign issue_ready = !rst && !flush && (r_pending < DEPTH_C);

  assign w_accept = res_valid && res_ready;
  assign w_inc    = issue_s && issue_ready;
  assign w_dec    = w_accept && res_s;
  assign w_upd    = w_dec && res_cond_pass;

  nzcv_compute #(
    .DATA_W (DATA_W)
  ) u_compute (
    .i_nzcv     (r_nzcv),
    .i_value    (res_value),
    .i_carry    (res_carry),
    .i_overflow (res_overflow),
    .i_class    (res_class),
    .o_nzcv     (w_nzcv_nxt)
  );

  // Next pending count; a retire with nothing pending saturates at zero.
  always_comb begin
    w_pending_nxt = r_pending;
    w_underflow   = 1'b0;
    if (flush) begin
      w_pending_nxt = ZERO_C;
    end else if (w_inc && !w_dec) begin
      w_pending_nxt = r_pending + ONE_C;
    end else if (w_dec && !w_inc) begin
      if (r_pending == ZERO_C) begin
        w_underflow = 1'b1;
      end else begin
        w_pending_nxt = r_pending - ONE_C;
      end
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Flag register, pending counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nzcv    <= 4'b0000;
      r_pending <= ZERO_C;
      r_err     <= 1'b0;
    end else begin
      if (w_upd) begin
        r_nzcv <= w_nzcv_nxt;
      end
      r_pending <= w_pending_nxt;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign nzcv_out      = r_nzcv;
  assign nzcv_stable   = (r_pending == ZERO_C);
  assign underflow_err = r_err;

`ifdef NZCV_BYPASS_EN
  assign nzcv_fwd        = w_upd ? w_nzcv_nxt : r_nzcv;
  assign nzcv_stable_fwd = (r_pending == ZERO_C) ||
                           ((r_pending == ONE_C) && w_dec && !w_inc);
`endif

endmodule

// File: tb/tb_nzcv_flag_writer.sv
// Self-checking bench for nzcv_flag_writer: directed vector table, a few
// hand-written sequences, then random stimulus against a reference model.
module tb_nzcv_flag_writer;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, issue_s, res_valid, res_carry, res_overflow;
  logic          res_s, res_cond_pass, flush;
  logic [DW-1:0] res_value;
  logic [1:0]    res_class;
  logic          issue_ready, res_ready, nzcv_stable, underflow_err;
  logic [3:0]    nzcv_out;
`ifdef NZCV_BYPASS_EN
  logic [3:0]    nzcv_fwd;
  logic          nzcv_stable_fwd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nzcv_flag_writer #(.DATA_W(DW), .PIPE_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_s       (issue_s),
    .issue_ready   (issue_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_value     (res_value),
    .res_carry     (res_carry),
    .res_overflow  (res_overflow),
    .res_class     (res_class),
    .res_s         (res_s),
    .res_cond_pass (res_cond_pass),
    .flush         (flush),
`ifdef NZCV_BYPASS_EN
    .nzcv_fwd        (nzcv_fwd),
    .nzcv_stable_fwd (nzcv_stable_fwd),
`endif
    .nzcv_out      (nzcv_out),
    .nzcv_stable   (nzcv_stable),
    .underflow_err (underflow_err)
  );

  typedef struct {
    logic          iss, val, s, cp, fl;
    logic [1:0]    cls;
    logic [DW-1:0] value;
    logic          c, v;
    logic [3:0]    e_nzcv;
    logic          e_st, e_ir, e_err;
  } vec_t;

  vec_t vq[$];

  // Reference model state
  logic [3:0] m_nzcv;
  int         m_pend;
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iss, val, s, cp, fl, input logic [1:0] cls,
                     input logic [DW-1:0] value, input logic c, v,
                     input logic [3:0] en, input logic est, eir, eerr);
    vec_t t;
    t.iss = iss; t.val = val; t.s = s; t.cp = cp; t.fl = fl; t.cls = cls;
    t.value = value; t.c = c; t.v = v;
    t.e_nzcv = en; t.e_st = est; t.e_ir = eir; t.e_err = eerr;
    vq.push_back(t);
  endtask

  task automatic idle();
    issue_s = 1'b0; res_valid = 1'b0; res_s = 1'b0; res_cond_pass = 1'b0;
    flush = 1'b0; res_class = 2'b00; res_value = '0;
    res_carry = 1'b0; res_overflow = 1'b0;
  endtask

  // Flags as the architecture defines them for each result class.
  function automatic logic [3:0] ref_flags(input logic [3:0] old, input logic [1:0] cls,
                                           input logic [DW-1:0] value, input logic c, v);
    logic n, z;
    n = value[DW-1];
    z = (value == 0);
    case (cls)
      2'd0:    return {n, z, c, old[0]};
      2'd1:    return {n, z, c, v};
      2'd2:    return {n, z, old[1:0]};
      default: return value[DW-1 -: 4];
    endcase
  endfunction

  task automatic model_step();
    logic inc, dec;
    if (rst) begin
      m_nzcv = 4'b0000; m_pend = 0; m_err = 1'b0;
    end else if (flush) begin
      m_pend = 0;
    end else begin
      inc = issue_s && (m_pend < DEPTH);
      dec = res_valid && res_s;
      if (dec && res_cond_pass)
        m_nzcv = ref_flags(m_nzcv, res_class, res_value, res_carry, res_overflow);
      if (inc && !dec) m_pend++;
      else if (dec && !inc) begin
        if (m_pend == 0) m_err = 1'b1;
        else m_pend--;
      end
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst issue_ready", issue_ready, 1'b0);
    check("rst res_ready", res_ready, 1'b0);
    @(posedge clk); #1;
    check("rst nzcv", nzcv_out, 4'b0000);
    check("rst stable", nzcv_stable, 1'b1);
    check("rst err", underflow_err, 1'b0);
    rst = 1'b0;
    #1;
    check("post-rst issue_ready", issue_ready, 1'b1);
  endtask

  initial begin
    // iss val s cp fl cls value c v | nzcv st ir err
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0000, 0,1,0);
    add(0,1,1,1,0, 2'd1, 32'h0,         1,0, 4'b0110, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0110, 0,1,0);
    add(0,1,1,1,0, 2'd3, 32'hF000_0000, 0,0, 4'b1111, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b1111, 0,1,0);
    add(0,1,1,1,0, 2'd0, 32'h8000_0001, 0,0, 4'b1001, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b1001, 0,1,0);
    add(0,1,1,1,0, 2'd2, 32'h0,         1,0, 4'b0101, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0101, 0,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0101, 0,0,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0101, 0,0,0);
    add(0,1,1,0,0, 2'd1, 32'h0,         1,1, 4'b0101, 0,1,0);
    add(1,1,1,1,0, 2'd1, 32'h1,         0,0, 4'b0000, 0,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0000, 0,0,0);
    add(1,1,1,1,1, 2'd1, 32'h0,         1,1, 4'b0000, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0000, 0,1,0);
    add(0,1,1,1,0, 2'd0, 32'h1,         1,0, 4'b0010, 1,1,0);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b0010, 0,1,0);
    add(0,1,1,0,0, 2'd1, 32'h0,         0,1, 4'b0010, 1,1,0);
    add(0,1,1,1,0, 2'd0, 32'h8000_0000, 0,0, 4'b1000, 1,1,1);
    add(0,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b1000, 1,1,1);
    add(1,0,0,0,0, 2'd0, 32'h0,         0,0, 4'b1000, 0,1,1);
    add(0,1,1,1,0, 2'd3, 32'hA000_0000, 0,0, 4'b1010, 1,1,1);
    add(0,1,0,1,0, 2'd0, 32'h0,         1,1, 4'b1010, 1,1,1);

    rst = 1'b1;
    idle();
    do_reset();

    for (int i = 0; i < vq.size(); i++) begin
      issue_s = vq[i].iss; res_valid = vq[i].val; res_s = vq[i].s;
      res_cond_pass = vq[i].cp; flush = vq[i].fl; res_class = vq[i].cls;
      res_value = vq[i].value; res_carry = vq[i].c; res_overflow = vq[i].v;
      #1;
      check($sformatf("row%0d res_ready", i), res_ready, !vq[i].fl);
      @(posedge clk); #1;
      idle();
      #1;
      check($sformatf("row%0d nzcv", i), nzcv_out, vq[i].e_nzcv);
      check($sformatf("row%0d stable", i), nzcv_stable, vq[i].e_st);
      check($sformatf("row%0d issue_ready", i), issue_ready, vq[i].e_ir);
      check($sformatf("row%0d err", i), underflow_err, vq[i].e_err);
    end

    // rst and flush together with work pending and a result offered
    issue_s = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1; issue_s = 1'b1;
    res_valid = 1'b1; res_s = 1'b1; res_cond_pass = 1'b1;
    res_class = 2'd3; res_value = 32'h5000_0000;
    @(posedge clk); #1;
    rst = 1'b0; idle();
    #1;
    check("rst+flush nzcv", nzcv_out, 4'b0000);
    check("rst+flush stable", nzcv_stable, 1'b1);
    check("rst+flush err", underflow_err, 1'b0);
    check("rst+flush issue_ready", issue_ready, 1'b1);

    // Random phase against the reference model
    m_nzcv = 4'b0000; m_pend = 0; m_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst           = ($urandom_range(0, 39) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      issue_s       = $urandom_range(0, 1);
      res_valid     = $urandom_range(0, 1);
      res_s         = ($urandom_range(0, 3) != 0);
      res_cond_pass = ($urandom_range(0, 3) != 0);
      res_class     = 2'($urandom_range(0, 3));
      res_value     = ($urandom_range(0, 3) == 0) ? 32'h0 : DW'($urandom);
      res_carry     = $urandom_range(0, 1);
      res_overflow  = $urandom_range(0, 1);
      #1;
      check("rnd issue_ready", issue_ready, !rst && !flush && (m_pend < DEPTH));
      check("rnd res_ready", res_ready, !rst && !flush);
`ifdef NZCV_BYPASS_EN
      begin
        logic acc_s, iss_ok;
        acc_s  = !rst && !flush && res_valid && res_s;
        iss_ok = !rst && !flush && issue_s && (m_pend < DEPTH);
        check("rnd fwd", nzcv_fwd, (acc_s && res_cond_pass) ?
              ref_flags(m_nzcv, res_class, res_value, res_carry, res_overflow) : m_nzcv);
        check("rnd stable_fwd", nzcv_stable_fwd,
              (m_pend == 0) || (m_pend == 1 && acc_s && !iss_ok));
      end
`endif
      model_step();
      @(posedge clk); #1;
      check("rnd nzcv", nzcv_out, m_nzcv);
      check("rnd stable", nzcv_stable, m_pend == 0);
      check("rnd err", underflow_err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_writer.md
Name: nzcv_flag_writer

Overview:
Producer side of the ARMv4 condition-flag interface. Computes N/Z/C/V from execute-stage results and holds the architectural NZCV register that the condition evaluator reads. Tracks in-flight flag-setting (S-bit) instructions so the condition evaluator can stall until the flags are current. Sits between ALU/shifter write-back and the condition-check logic.

Parameters:
DATA_W, 32, ALU result width; N is taken from bit DATA_W-1.
PIPE_DEPTH, 2, maximum in-flight S-bit instructions tracked; counter width is clog2(PIPE_DEPTH+1).

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
issue_s  in  1  S-bit instruction entering execute this cycle (counts only when issue_ready=1)
issue_ready  out  1  high while pending < PIPE_DEPTH, rst=0 and flush=0
res_valid  in  1  result presented
res_ready  out  1  equals !rst && !flush
res_value  in  DATA_W  ALU result
res_carry  in  1  ALU carry for arithmetic ops; shifter carry-out for logical ops
res_overflow  in  1  ALU signed overflow
res_class  in  2  00 logical, 01 arithmetic, 10 multiply, 11 MSR-flags
res_s  in  1  result belongs to an S-bit instruction (or an MSR-flags write)
res_cond_pass  in  1  instruction passed its condition check
flush  in  1  pipeline flush
nzcv_out  out  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V
nzcv_stable  out  1  high when pending==0
underflow_err  out  1  sticky; set on a retire with pending==0

Behaviour:
- Reset, held while rst=1: nzcv_out=4'b0000, pending=0, underflow_err=0, nzcv_stable=1. issue_ready=0 and res_ready=0 during reset.
- Accept: res_valid && res_ready.
- Flag update, when accept && res_s && res_cond_pass:
  - The new value appears on nzcv_out the cycle after accept (latency 1).
  - Class 00 (logical): N=res_value[DATA_W-1]; Z=(res_value==0); C=res_carry; V unchanged.
  - Class 01 (arithmetic): N, Z as above; C=res_carry; V=res_overflow.
  - Class 10 (multiply): N, Z as above; C and V unchanged (ARMv4 C is UNPREDICTABLE here; the decision is to keep C).
  - Class 11 (MSR-flags): nzcv = res_value[DATA_W-1:DATA_W-4].
- If accept && res_s && !res_cond_pass: flags are unchanged, but the instruction still retires from the pending count.
- Pending counter:
  - Increments on issue_s && issue_ready.
  - Decrements on accept && res_s.
  - Both in the same cycle: net unchanged.
  - Never exceeds PIPE_DEPTH, because issue is blocked at full.
- Underflow: a decrement with pending==0 and no simultaneous increment leaves the count at 0 and sets underflow_err. It clears only on rst.
- Flush:
  - Next cycle pending=0.
  - No accept, no issue and no flag update in the flush cycle.
  - nzcv_out holds its value.
- Flush and rst together: rst dominates; the result is identical in effect.
- nzcv_stable is combinational from the registered counter. It rises in the cycle after the last retire, the same cycle the new flags become visible.

Optional Feature:
NZCV_BYPASS_EN:
- Defined: adds output nzcv_fwd[3:0]. It equals the next-state flags when an update accept occurs this cycle, otherwise nzcv_out. nzcv_stable_fwd is also added: high when pending==0, or when pending==1 and a retire is being accepted with no issue this cycle. Together these give zero-cycle forwarding to the condition evaluator.
- Undefined: neither port exists; consumers use nzcv_out and nzcv_stable only.

Decomposition:
- Package nzcv_pkg holds:
  - Flag index constants: N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
  - res_class codes: CLS_LOGIC, CLS_ARITH, CLS_MUL, CLS_MSR.
  - nzcv_t, a 4-bit typedef.
- Sub-module nzcv_compute: purely combinational next-flag function taking (current nzcv, res_value, res_carry, res_overflow, res_class) and returning the next nzcv. The top level keeps the flag register, pending counter, handshake and error logic.

Test Plan:
- Reset then idle: nzcv_out=0000, nzcv_stable=1, issue_ready=1 after rst falls.
- Issue S-ADD, then accept with class 01, value 0x0000_0000, carry=1, ovf=0, cond_pass=1: next cycle nzcv_out=0110; stable goes 0 then 1.
- Preload 1111, then logical result 0x8000_0001, carry=0: nzcv_out=1001 (V held at 1). Multiply result 0x0 from 1001: nzcv_out=0101.
- Issue two S-instructions: issue_ready=0 at pending=2. A third issue_s is ignored. Issue and retire in the same cycle keep pending=2.
- Retire with cond_pass=0 from nzcv=0010: flags stay 0010 and pending decrements. Retire at pending=0: underflow_err=1 and stays 1 until rst.
- With pending=2, assert flush: res_ready=0 that cycle, next cycle pending=0 and nzcv_stable=1, flags unchanged. MSR class 11 with value 0xA000_0000: nzcv_out=1010.
